// File: rtl/multiplier.sv
// Sequential shift-add multiplier for MUL/IMUL, 8- and 16-bit forms.
// Optional early termination: define MULTIPLIER_EARLY_OUT_EN.
module multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_8_bit,
  input  logic        is_signed,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        complete,
  output logic [31:0] product,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE,
    WORKING,
    FIX_SIGN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        is8_q, is8_d;
  logic        sgn_q, sgn_d;
  logic [31:0] product_q, product_d;
  logic        overflow_q, overflow_d;
  logic        complete_q, complete_d;

  logic        a_sgn, b_sgn;
  logic [7:0]  a_neg8, b_neg8;
  logic [15:0] a_neg16, b_neg16;
  logic [15:0] a_mag, b_mag;
  logic [31:0] res;
  logic        ovf8, ovf16;

  assign a_sgn   = is_8_bit ? a[7] : a[15];
  assign b_sgn   = is_8_bit ? b[7] : b[15];
  assign a_neg8  = ~a[7:0] + 8'd1;
  assign b_neg8  = ~b[7:0] + 8'd1;
  assign a_neg16 = ~a + 16'd1;
  assign b_neg16 = ~b + 16'd1;

  // -128 / -32768 negate to themselves, which is the correct unsigned magnitude
  assign a_mag = (is_signed && a_sgn)
               ? (is_8_bit ? {8'b0, a_neg8} : a_neg16)
               : (is_8_bit ? {8'b0, a[7:0]} : a);
  assign b_mag = (is_signed && b_sgn)
               ? (is_8_bit ? {8'b0, b_neg8} : b_neg16)
               : (is_8_bit ? {8'b0, b[7:0]} : b);

  assign res   = neg_q ? (~acc_q + 32'd1) : acc_q;
  assign ovf8  = sgn_q ? (res[15:8] != {8{res[7]}})
                       : (|res[15:8]);
  assign ovf16 = sgn_q ? (res[31:16] != {16{res[15]}})
                       : (|res[31:16]);

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    is8_d      = is8_q;
    sgn_d      = sgn_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    complete_d = complete_q;
    unique case (state_q)
      IDLE: begin
        complete_d = 1'b0;
        if (start) begin
          mcand_d  = {16'b0, a_mag};
          mplier_d = b_mag;
          acc_d    = 32'd0;
          cnt_d    = is_8_bit ? 4'd7 : 4'd15;
          neg_d    = is_signed & (a_sgn ^ b_sgn);
          is8_d    = is_8_bit;
          sgn_d    = is_signed;
          state_d  = WORKING;
`ifdef MULTIPLIER_EARLY_OUT_EN
          if (b_mag == 16'd0) state_d = FIX_SIGN;
`endif
        end
      end
      WORKING: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = FIX_SIGN;
`ifdef MULTIPLIER_EARLY_OUT_EN
        if (mplier_d == 16'd0) state_d = FIX_SIGN;
`endif
      end
      FIX_SIGN: begin
        product_d  = is8_q ? {16'b0, res[15:0]} : res;
        overflow_d = is8_q ? ovf8 : ovf16;
        complete_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      is8_q      <= 1'b0;
      sgn_q      <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      is8_q      <= is8_d;
      sgn_q      <= sgn_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      complete_q <= complete_d;
    end
  end

  assign busy     = start || (state_q != IDLE && !complete_q);
  assign complete = complete_q;
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier: arithmetic model, latency and handshake.
// Builds with or without MULTIPLIER_EARLY_OUT_EN.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_8_bit;
  logic        is_signed;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        complete;
  logic [31:0] product;
  logic        overflow;

  multiplier dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_8_bit  (is_8_bit),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .complete  (complete),
    .product   (product),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic        o;
    int          k;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [15:0] av, logic [15:0] bv,
                                 logic s, logic e);
    exp_t r;
    longint x, y, p, lim, bm;
    logic signed [7:0]  a8, b8;
    logic signed [15:0] a16, b16;
    logic [63:0] pv;
    int w;
    a8 = av[7:0];
    b8 = bv[7:0];
    a16 = av;
    b16 = bv;
    if (e) begin
      x = s ? longint'(a8) : longint'(av[7:0]);
      y = s ? longint'(b8) : longint'(bv[7:0]);
      lim = 256;
    end else begin
      x = s ? longint'(a16) : longint'(av);
      y = s ? longint'(b16) : longint'(bv);
      lim = 65536;
    end
    p = x * y;
    pv = p;
    r.p = e ? {16'b0, pv[15:0]} : pv[31:0];
    if (s) r.o = (p < -(lim / 2)) || (p >= lim / 2);
    else   r.o = (p >= lim);
    bm = (y < 0) ? -y : y;
`ifdef MULTIPLIER_EARLY_OUT_EN
    w = 0;
    for (int i = 0; i < 16; i++) if (bm[i]) w = i + 1;
`else
    w = e ? 8 : 16;
`endif
    r.lat = w + 1;
    r.k = 0;
    return r;
  endfunction

  // drive in the current cycle; accepted at the next rising edge
  task automatic launch(logic [15:0] av, logic [15:0] bv,
                        logic s, logic e);
    exp_t x;
    a = av;
    b = bv;
    is_signed = s;
    is_8_bit = e;
    start = 1'b1;
    x = model(av, bv, s, e);
    x.k = cyc + 1;
    q.push_back(x);
    @(posedge clk);
    #2;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    is_signed = $urandom;
    is_8_bit = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      check("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_complete();
    int n;
    n = 0;
    while (!complete && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!complete) check("no_complete", 32'(complete), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!reset) begin
      if (q.size() != 0)
        check("busy", 32'(busy), 32'(start || !complete));
      if (complete) begin
        if (q.size() == 0) begin
          check("spurious_complete", 32'd1, 32'd0);
        end else begin
          x = q.pop_front();
          check("product", product, x.p);
          check("overflow", 32'(overflow), 32'(x.o));
          check("latency", 32'(cyc - x.k), 32'(x.lat));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    is_8_bit = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_product", product, 32'd0);
    check("rst_complete", 32'(complete), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #2;

    launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    wait_idle();
    launch(16'h12FF, 16'h0002, 1'b0, 1'b1);
    wait_idle();
    launch(16'h0010, 16'h000F, 1'b0, 1'b1);
    wait_idle();
    launch(16'h0080, 16'h00FF, 1'b1, 1'b1);
    wait_idle();
    launch(16'h00FE, 16'h0003, 1'b1, 1'b1);
    wait_idle();
    launch(16'h8000, 16'h8000, 1'b1, 1'b0);
    wait_idle();
    launch(16'hFFFF, 16'h0005, 1'b1, 1'b0);
    wait_idle();

    // start pulsed mid-operation must be ignored
    launch(16'h0123, 16'h0456, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    a = 16'h7777;
    b = 16'h9999;
    is_signed = 1'b1;
    is_8_bit = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_idle();

    // start in the complete cycle is accepted
    launch(16'hFF80, 16'h0081, 1'b1, 1'b0);
    wait_complete();
    launch(16'h00C3, 16'h007F, 1'b1, 1'b1);
    wait_idle();

    // asynchronous reset at WORKING cycle 5
    launch(16'h4321, 16'h1234, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    q.delete();
    reset = 1'b1;
    #1;
    check("midrst_product", product, 32'd0);
    check("midrst_complete", 32'(complete), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    launch(16'd3, 16'd7, 1'b0, 1'b0);
    wait_idle();

`ifdef MULTIPLIER_EARLY_OUT_EN
    launch(16'h1234, 16'h0000, 1'b0, 1'b0);
    wait_idle();
    launch(16'h1234, 16'h0003, 1'b0, 1'b0);
    wait_idle();
`endif

    for (int i = 0; i < 30; i++) begin
      launch(16'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom));
      if (i % 3 == 0) wait_complete();
      else wait_idle();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
